// File: rtl/conv1_maxpool.sv
// -----------------------------------------------------------------------------
// conv1_maxpool
//
// Purpose:
//   This block is a 2x2, stride-2 max-pooling stage that sits after conv1. It
//   takes three parallel signed feature-map streams. Each stream is WIDTH x
//   HEIGHT, arrives in raster order, and carries one pixel per channel on each
//   valid_in. The block emits three (WIDTH/2) x (HEIGHT/2) pooled streams.
//
//   Each channel keeps a half-width line buffer. On even rows, the buffer stores
//   the horizontal max of each column pair. On odd rows, that stored value is
//   combined with the current pair. A full frame never needs to be stored.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous reset, active-high
//   valid_in        qualifies data_in_1..3 for one pixel
//   data_in_1..3    signed conv1 samples, DATA_BITS wide
//   data_out_1..3   signed pooled samples, held between pulses
//   valid_out_pool  one-cycle pulse per pooled sample; it comes 1 clk after
//                   the bottom-right pixel of each 2x2 window
//   frame_done      one-cycle pulse that coincides with the last pooled sample
//                   of a frame
//
// Build option:
//   CONV1_MAXPOOL_RELU_EN  When defined, a negative pooled result is clamped
//                          to 0 at the output register. Timing and valid
//                          behaviour do not change.
// -----------------------------------------------------------------------------
module conv1_maxpool #(
  parameter int WIDTH     = 24,
  parameter int HEIGHT    = 24,
  parameter int DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in_1,
  input  logic [DATA_BITS-1:0] data_in_2,
  input  logic [DATA_BITS-1:0] data_in_3,
  output logic [DATA_BITS-1:0] data_out_1,
  output logic [DATA_BITS-1:0] data_out_2,
  output logic [DATA_BITS-1:0] data_out_3,
  output logic                 valid_out_pool,
  output logic                 frame_done
);

  localparam int NUM_CH = 3;
  localparam int HALF_W = WIDTH / 2;
  localparam int COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  typedef logic signed [DATA_BITS-1:0] sample_t;

  // Full-width signed max. On a tie either operand is correct, because both
  // operands are equal.
  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  // Transform applied just before the output register.
  function automatic sample_t out_stage(input sample_t v);
`ifdef CONV1_MAXPOOL_RELU_EN
    return v[DATA_BITS-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  sample_t hold_q [NUM_CH];             // left pixel of the current column pair
  sample_t hold_d [NUM_CH];
  sample_t lbuf_q [NUM_CH][HALF_W];     // horizontal maxima from the even row
  sample_t lbuf_d [NUM_CH][HALF_W];
  sample_t dout_q [NUM_CH];
  sample_t dout_d [NUM_CH];

  logic valid_q, valid_d;
  logic done_q,  done_d;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  sample_t          din    [NUM_CH];
  sample_t          hmax   [NUM_CH];
  sample_t          result [NUM_CH];
  logic [IDX_W-1:0] lb_idx;
  logic             last_col;
  logic             last_row;
  logic             col_odd;
  logic             row_odd;

  assign din[0] = sample_t'(data_in_1);
  assign din[1] = sample_t'(data_in_2);
  assign din[2] = sample_t'(data_in_3);

  // A column pair (2k, 2k+1) maps to line-buffer entry k.
  assign lb_idx   = IDX_W'(col_q >> 1);
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);
  assign col_odd  = col_q[0];
  assign row_odd  = row_q[0];

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      hmax[ch]   = smax(hold_q[ch], din[ch]);
      result[ch] = smax(lbuf_q[ch][lb_idx], hmax[ch]);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d signal is given its hold value first. Without that, a
    // path that skips an assignment would infer a latch.
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    lbuf_d  = lbuf_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    if (valid_in) begin
      // Raster counters. The last pixel of a frame wraps straight to (0,0),
      // so back-to-back frames need no idle cycle.
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (!col_odd) begin
          hold_d[ch] = din[ch];
        end else if (!row_odd) begin
          // The even row writes entry k before the odd row reads it. This is
          // why a new frame's row 0 can safely overwrite the previous frame's
          // entries.
          lbuf_d[ch][lb_idx] = hmax[ch];
        end else begin
          dout_d[ch] = out_stage(result[ch]);
        end
      end

      valid_d = col_odd && row_odd;
      done_d  = last_col && last_row;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        hold_q[ch] <= '0;
        dout_q[ch] <= '0;
        // NOTE: the line buffer lives in flops and is cleared along with
        // everything else. An aborted frame therefore leaves nothing behind,
        // which a RAM macro could not guarantee.
        for (int e = 0; e < HALF_W; e++) begin
          lbuf_q[ch][e] <= '0;
        end
      end
    end else begin
      // NOTE: the clocked block uses only non-blocking assignments. Every
      // register then samples the pre-edge value of every other register.
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
      lbuf_q  <= lbuf_d;
      dout_q  <= dout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign data_out_1     = dout_q[0];
  assign data_out_2     = dout_q[1];
  assign data_out_3     = dout_q[2];
  assign valid_out_pool = valid_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_conv1_maxpool.sv
// -----------------------------------------------------------------------------
// tb_conv1_maxpool
//
// Self-checking bench for conv1_maxpool. A table of frame patterns is applied
// in a loop. A reference model pools each whole frame as a 2-D array. A monitor
// then checks every output cycle against the model. Hand-written sequences
// cover back-to-back frames and a reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_conv1_maxpool;

  localparam int W  = 24;
  localparam int H  = 24;
  localparam int DB = 12;
  localparam int NP = (W / 2) * (H / 2);

  typedef enum int {K_RAMP, K_NEG, K_CONST, K_COL, K_RAND} kind_e;

  // One table record: the pattern for each channel, the bubble length, and
  // the hand-derived first and last pooled values for each channel.
  typedef struct {
    string name;
    kind_e k1, k2, k3;
    int    o1, o2, o3;
    int    gap;
    int    f1, f2, f3;
    int    l1, l2, l3;
  } vec_t;

  typedef struct {
    int d1, d2, d3;
    bit done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DB-1:0] data_in_1, data_in_2, data_in_3;
  logic [DB-1:0] data_out_1, data_out_2, data_out_3;
  logic          valid_out_pool;
  logic          frame_done;

  conv1_maxpool #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .data_in_1      (data_in_1),
    .data_in_2      (data_in_2),
    .data_in_3      (data_in_3),
    .data_out_1     (data_out_1),
    .data_out_2     (data_out_2),
    .data_out_3     (data_out_3),
    .valid_out_pool (valid_out_pool),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulse_cnt = 0;
  int   done_cnt  = 0;
  bit   exp_br = 1'b0;      // high while the pixel being driven completes a window
  exp_t exp_q[$];
  int   got1[$], got2[$], got3[$];
  int   px [3][H][W];

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int rel(input int v);
`ifdef CONV1_MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int trunc(input int v);
    logic signed [DB-1:0] s;
    s = v[DB-1:0];
    return int'(s);
  endfunction

  function automatic int gen(input kind_e k, input int off, input int r, input int c);
    case (k)
      K_RAMP:  return trunc(r * W + c + off);
      K_NEG:   return (r == 1 && c == 1) ? -5 : -100;
      K_CONST: return trunc(off);
      K_COL:   return trunc(c + off);
      default: return trunc(int'($urandom));
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in  = 1'b0;
      exp_br    = 1'b0;
      data_in_1 = DB'($urandom);
      data_in_2 = DB'($urandom);
      data_in_3 = DB'($urandom);
    end
  endtask

  // Builds a frame, queues the model's pooled results, then drives the frame
  // pixels. Driving stops after stop_after pixels.
  task automatic run_frame(input kind_e k1, input kind_e k2, input kind_e k3,
                           input int o1, input int o2, input int o3,
                           input int gap, input bit rand_gap, input int stop_after);
    int   n;
    int   g;
    int   v;
    exp_t e;
    int   m [3];
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        px[0][r][c] = gen(k1, o1, r, c);
        px[1][r][c] = gen(k2, o2, r, c);
        px[2][r][c] = gen(k3, o3, r, c);
      end
    end
    // Reference: each output is the max over its 2x2 window.
    for (int i = 0; i < H / 2; i++) begin
      for (int j = 0; j < W / 2; j++) begin
        for (int ch = 0; ch < 3; ch++) begin
          m[ch] = px[ch][2*i][2*j];
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (px[ch][2*i+dr][2*j+dc] > m[ch]) m[ch] = px[ch][2*i+dr][2*j+dc];
        end
        e.d1   = rel(m[0]);
        e.d2   = rel(m[1]);
        e.d3   = rel(m[2]);
        e.done = (i == H / 2 - 1) && (j == W / 2 - 1);
        exp_q.push_back(e);
      end
    end
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n == stop_after) return;
        @(negedge clk);
        valid_in  = 1'b1;
        exp_br    = (r % 2 == 1) && (c % 2 == 1);
        v = px[0][r][c]; data_in_1 = v[DB-1:0];
        v = px[1][r][c]; data_in_2 = v[DB-1:0];
        v = px[2][r][c]; data_in_3 = v[DB-1:0];
        n++;
        g = rand_gap ? int'($urandom_range(gap, 0)) : gap;
        if (g > 0) idle(g);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("valid_out_pool", valid_out_pool, exp_br);
        if (valid_out_pool) begin
          pulse_cnt++;
          if (frame_done) done_cnt++;
          got1.push_back(int'($signed(data_out_1)));
          got2.push_back(int'($signed(data_out_2)));
          got3.push_back(int'($signed(data_out_3)));
          if (exp_q.size() == 0) begin
            check("scoreboard_underflow", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("data_out_1", $signed(data_out_1), e.d1);
            check("data_out_2", $signed(data_out_2), e.d2);
            check("data_out_3", $signed(data_out_3), e.d3);
            check("frame_done", frame_done, e.done);
          end
        end else begin
          check("frame_done_idle", frame_done, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_data_out_1"}, data_out_1, 0);
    check({tag, "_data_out_2"}, data_out_2, 0);
    check({tag, "_data_out_3"}, data_out_3, 0);
    check({tag, "_valid"},      valid_out_pool, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic check_first_last(input string tag, input int f1, input int f2,
                                  input int f3, input int l1, input int l2, input int l3);
    int last;
    check({tag, "_count"}, got1.size(), NP);
    if (got1.size() == NP) begin
      last = NP - 1;
      check({tag, "_first1"}, got1[0], f1);
      check({tag, "_first2"}, got2[0], f2);
      check({tag, "_first3"}, got3[0], f3);
      check({tag, "_last1"},  got1[last], l1);
      check({tag, "_last2"},  got2[last], l2);
      check({tag, "_last3"},  got3[last], l3);
    end
  endtask

  initial begin
    vec_t vecs [4];
    int   d0;
    int   p0;

    vecs[0] = '{"ramp_mix", K_RAMP, K_NEG, K_COL, 0, 0, 0, 0,
                25, rel(-5), 1, 575, rel(-100), 23};
    vecs[1] = '{"indep", K_CONST, K_CONST, K_COL, 7, -7, 0, 0,
                7, rel(-7), 1, 7, rel(-7), 23};
    vecs[2] = '{"bubbles", K_RAMP, K_RAMP, K_NEG, 0, 1000, 0, 3,
                25, 1025, rel(-5), 575, 1575, rel(-100)};
    vecs[3] = '{"extremes", K_CONST, K_CONST, K_COL, -2048, 2047, -30, 1,
                rel(-2048), 2047, rel(-29), rel(-2048), 2047, rel(-7)};

    rst = 1'b1; valid_in = 1'b0; exp_br = 1'b0;
    data_in_1 = '0; data_in_2 = '0; data_in_3 = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Table-driven frames.
    for (int v = 0; v < 4; v++) begin
      got1.delete(); got2.delete(); got3.delete();
      d0 = done_cnt;
      run_frame(vecs[v].k1, vecs[v].k2, vecs[v].k3, vecs[v].o1, vecs[v].o2,
                vecs[v].o3, vecs[v].gap, 1'b0, W * H);
      idle(4);
      check_first_last(vecs[v].name, vecs[v].f1, vecs[v].f2, vecs[v].f3,
                       vecs[v].l1, vecs[v].l2, vecs[v].l3);
      check({vecs[v].name, "_done_pulses"}, done_cnt - d0, 1);
    end

    // Back-to-back ramp frames, the second offset by +1000.
    got1.delete(); got2.delete(); got3.delete();
    d0 = done_cnt;
    run_frame(K_RAMP, K_COL, K_CONST, 0, 0, 5, 0, 1'b0, W * H);
    run_frame(K_RAMP, K_COL, K_CONST, 1000, 0, 5, 0, 1'b0, W * H);
    idle(4);
    check("b2b_count", got1.size(), 2 * NP);
    check("b2b_done_pulses", done_cnt - d0, 2);
    if (got1.size() == 2 * NP) begin
      check("b2b_first_f1", got1[0], 25);
      check("b2b_first_f2", got1[NP], 1025);
      check("b2b_last_f2",  got1[2 * NP - 1], 1575);
    end

    // Random frames with random bubbles.
    for (int f = 0; f < 3; f++) begin
      p0 = pulse_cnt;
      d0 = done_cnt;
      run_frame(K_RAND, K_RAND, K_RAND, 0, 0, 0, 2, 1'b1, W * H);
      idle(3);
      check("rand_count", pulse_cnt - p0, NP);
      check("rand_done_pulses", done_cnt - d0, 1);
    end

    // Reset after 300 pixels, then one fresh frame.
    p0 = pulse_cnt;
    run_frame(K_RAMP, K_RAND, K_NEG, 0, 0, 0, 0, 1'b0, 300);
    @(posedge clk);
    #3;
    valid_in = 1'b0;
    exp_br   = 1'b0;
    check("abort_pulses", pulse_cnt - p0, 72);
    check("pre_reset_hold", data_out_1, 287);
    rst = 1'b1;
    #1;
    check_reset_state("midreset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got1.delete(); got2.delete(); got3.delete();
    d0 = done_cnt;
    run_frame(vecs[0].k1, vecs[0].k2, vecs[0].k3, vecs[0].o1, vecs[0].o2,
              vecs[0].o3, 0, 1'b0, W * H);
    idle(4);
    check_first_last("post_reset", vecs[0].f1, vecs[0].f2, vecs[0].f3,
                     vecs[0].l1, vecs[0].l2, vecs[0].l3);
    check("post_reset_done_pulses", done_cnt - d0, 1);

    check("scoreboard_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv1_maxpool.md
Name: conv1_maxpool

Overview:
- 2x2, stride-2 max-pooling stage directly downstream of the conv1 stage.
- Consumes the three parallel 12-bit signed conv1 feature-map streams (24x24 each, raster order, one pixel per channel per valid_in) and emits three 12x12 pooled streams to the next layer.
- Uses a half-width line buffer per channel, so each frame is processed without full-frame storage.

Parameters:
- WIDTH, 24, input feature-map columns (even).
- HEIGHT, 24, input feature-map rows (even).
- DATA_BITS, 12, signed sample width per channel.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous reset, active-high.
- valid_in  input  1  qualifies data_in_1..3 for one pixel.
- data_in_1  input  DATA_BITS  channel 1 conv sample (signed).
- data_in_2  input  DATA_BITS  channel 2 conv sample (signed).
- data_in_3  input  DATA_BITS  channel 3 conv sample (signed).
- data_out_1  output  DATA_BITS  channel 1 pooled sample (signed).
- data_out_2  output  DATA_BITS  channel 2 pooled sample (signed).
- data_out_3  output  DATA_BITS  channel 3 pooled sample (signed).
- valid_out_pool  output  1  one-cycle pulse per pooled sample.
- frame_done  output  1  one-cycle pulse coincident with the last pooled sample of a frame.

Behaviour:
- Reset (async, rst=1):
  - col/row counters, hold regs, line buffer, data_out_1..3, valid_out_pool and frame_done all clear to 0.
  - A partial frame is discarded; the first valid_in after release is pixel (0,0).
- Counters advance only on valid_in=1:
  - col runs 0..WIDTH-1; at WIDTH-1 it wraps to 0 and row increments.
  - row runs 0..HEIGHT-1; at row=HEIGHT-1, col=WIDTH-1 both wrap to 0 (next frame, no idle cycle needed).
- valid_in gaps of any length are legal; all state holds while valid_in=0.
- Per channel, on each valid pixel:
  - col even: hold <= data_in.
  - col odd: hmax = signed max(hold, data_in).
    - row even: linebuf[col>>1] <= hmax.
    - row odd: result = signed max(linebuf[col>>1], hmax).
- Output is registered:
  - On the cycle after an odd-row, odd-col valid pixel: data_out_n = result and valid_out_pool=1; otherwise valid_out_pool=0.
  - data_out_n holds its last value while valid_out_pool=0.
  - Latency: 1 clk from the bottom-right pixel of each 2x2 window.
- Per frame: (WIDTH/2)*(HEIGHT/2) = 144 valid_out_pool pulses, in raster order of the pooled map.
- frame_done=1 in the same cycle as the pulse for pooled (HEIGHT/2-1, WIDTH/2-1); 0 otherwise.
- Comparisons are full-width signed; no rounding or width growth; ties select either value (identical result).
- The line buffer is WIDTH/2 entries x DATA_BITS per channel. It is written only on even rows and read only on odd rows, so there is no read/write hazard.
- Back-to-back frames: row-0 writes of the new frame may overwrite entries of the previous frame only after their odd-row read.

Optional Feature:
- Macro: CONV1_MAXPOOL_RELU_EN
- Defined: ReLU is applied at the output register. A negative result is emitted as 0; a non-negative result passes unchanged. Timing and valid behaviour are unchanged.
- Undefined: the raw signed max is emitted, including negative values.

Test Plan:
- Ramp frame: ch1 pixel(r,c)=r*24+c truncated to 12 bits, continuous valid_in -> 144 outputs; out(i,j)=(2i+1)*24+2j+1 (first=25, last=575); frame_done with 144th pulse only.
- Negative data: ch2 all -100, except pixel(1,1)=-5 -> out(0,0)=-5, all other outputs -100. With CONV1_MAXPOOL_RELU_EN defined -> all outputs 0.
- Channel independence: ch1=+7, ch2=-7, ch3=pixel(r,c)=c, all constant across rows -> outputs 7, -7 and 2j+1 respectively.
- Bubbles: same ramp with valid_in low for 3 cycles after every pixel -> identical output sequence; each pulse 1 clk after its window's bottom-right pixel.
- Reset mid-frame: assert rst after 300 pixels -> outputs, valid_out_pool and frame_done go 0 immediately. A fresh full frame afterwards -> exactly 144 correct outputs, with no residue from the aborted frame.
- Back-to-back frames: two ramp frames with no gap, second offset by +1000 -> 288 pulses, second-frame out(0,0)=1025, frame_done pulses exactly twice.
